// File: rtl/rr_arb4.sv
// rr_arb4 -- four-source round-robin arbiter driving a 4:1 data mux.
//
// A winner is picked in IDLE by searching req_i starting at the priority
// pointer, registered into sel_o/gnt_o, and held for a burst of up to
// MAX_BURST accepted transfers. A grant ends early when the owner drops
// its request. Every release is followed by one IDLE cycle before the next
// grant, and the pointer moves to the source after the one just served.
//
// Ports
//   clk_i    in   clock, all state on rising edge
//   rst_i    in   synchronous active-high reset
//   req_i    in   [3:0] per-source requests, bit n selects mux input xn
//   ready_i  in   downstream accepts the mux output this cycle
//   sel_o    out  [1:0] mux select, index of the granted source
//   gnt_o    out  [3:0] one-hot grant, zero outside GRANT
//   valid_o  out  mux output valid (GRANT and owner still requesting)
//
// state  | meaning
// IDLE   | no owner; arbitrate on req_i at the next edge
// GRANT  | source sel_o owns the mux until withdraw or burst limit

module rr_arb4 #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  input  logic       ready_i,
  output logic [1:0] sel_o,
  output logic [3:0] gnt_o,
  output logic       valid_o
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] win_idx;
  logic       win_found;
  logic       owner_req;
  logic       xfer;
  logic       release_grant;

  // First requesting source in the order ptr, ptr+1, ptr+2, ptr+3; the
  // 2-bit add wraps naturally modulo 4.
  always_comb begin : winner_search
    logic [1:0] cand;
    cand      = '0;
    win_idx   = ptr_q;
    win_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && req_i[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  // Only the owner's request bit matters during GRANT; other bits are
  // looked at again only once the arbiter is back in IDLE.
  assign owner_req = req_i[sel_q];
  assign valid_o   = (state_q == ST_GRANT) & owner_req;
  assign xfer      = valid_o & ready_i;

  // The count is compared before incrementing, so it tops out at
  // MAX_BURST-1 and the MAX_BURST-th transfer triggers the release.
  assign release_grant = (state_q == ST_GRANT) &
                         (~owner_req | (xfer & (cnt_q == LAST_CNT)));

  always_comb begin : next_state
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_GRANT;
          sel_d   = win_idx;
          gnt_d   = 4'b0001 << win_idx;
          cnt_d   = '0;
        end else begin
          gnt_d = 4'b0000;
        end
      end
      ST_GRANT: begin
        if (release_grant) begin
          state_d = ST_IDLE;
          ptr_d   = sel_q + 2'd1;
          gnt_d   = 4'b0000;
          cnt_d   = '0;
        end else if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel_o = sel_q;
  assign gnt_o = gnt_q;

endmodule

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive accepted transfers per grant; legal range 1..16.
REQ-002 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port req_i, input, 4 bits; bit n is the request from source n, which drives mux data input xn.
REQ-005 SHALL have port ready_i, input, 1 bit; downstream accepts the selected data this cycle.
REQ-006 SHALL have port sel_o, output, 2 bits; the 4:1 mux select, equal to the granted source index.
REQ-007 SHALL have port gnt_o, output, 4 bits; one-hot grant, gnt_o[sel_o]=1 while in GRANT, else 0000.
REQ-008 SHALL have port valid_o, output, 1 bit; the mux output is valid this cycle.

Function
REQ-009 SHALL implement FSM states IDLE and GRANT only.
REQ-010 SHALL keep a 2-bit priority pointer ptr; the search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4.
REQ-011 SHALL, in IDLE with req_i != 0, register the winner (first set bit in search order) into sel_o and gnt_o, clear the burst count, and enter GRANT at the next edge.
REQ-012 SHALL, in IDLE with req_i == 0, stay in IDLE with gnt_o=0000, and hold sel_o and ptr.
REQ-013 SHALL have 1-cycle arbitration latency: a request seen in IDLE at edge k gives gnt_o at edge k+1.
REQ-014 SHALL drive valid_o combinationally as (state==GRANT) & req_i[sel_o].
REQ-015 SHALL define transfer as valid_o & ready_i; on each transfer the burst count increments.
REQ-016 SHALL release the grant when req_i[sel_o]==0 in GRANT (the requester withdrew; no transfer counted).
REQ-017 SHALL release the grant when a transfer occurs and the burst count equals MAX_BURST-1.
REQ-018 SHALL, on release, set ptr to sel_o+1 (3 wraps to 0), enter IDLE, and clear gnt_o at the next edge.
REQ-019 SHALL hold sel_o, gnt_o and the burst count in GRANT while valid_o=1 and ready_i=0 (backpressure); no timeout.
REQ-020 SHALL insert exactly one IDLE bubble cycle between consecutive grants, even if requests remain.
REQ-021 SHALL ignore changes to non-granted req_i bits while in GRANT.
REQ-022 SHALL size the burst counter as ceil(log2(MAX_BURST+1)) bits, and it SHALL never exceed MAX_BURST-1.
REQ-023 SHALL, with MAX_BURST=1, release after every single transfer.
REQ-024 SHALL keep sel_o stable for the whole GRANT period, so the mux output changes only at grant boundaries.

Reset
REQ-025 SHALL, when rst_i=1 at an edge, set state=IDLE, ptr=0, sel_o=00, gnt_o=0000 and burst count=0.
REQ-026 SHALL force valid_o=0 in the cycle after reset.
REQ-027 SHALL give reset priority over all other events, including a transfer in the same cycle.
REQ-028 SHALL, on reset during GRANT, drop the grant at that edge; the next arbitration starts from ptr=0.

Verification
REQ-029 SHALL cover: reset, then req_i=0100 held, ready_i=1 -> gnt_o=0100, sel_o=10 one cycle later; 4 transfers, release, 1 IDLE cycle, re-grant to source 2.
REQ-030 SHALL cover: req_i=1111 held, ready_i=1, MAX_BURST=4 -> grant order 0,1,2,3,0; each grant lasts 4 transfers; one bubble between grants.
REQ-031 SHALL cover: granted source 1 with ready_i=0 for 5 cycles -> valid_o=1, sel_o=01 stable, count unchanged; resumes on ready_i=1.
REQ-032 SHALL cover: granted source 3 drops req after 2 transfers -> valid_o=0 that cycle, release, ptr=0; with req_i=0001 the next grant goes to source 0.
REQ-033 SHALL cover: rst_i=1 mid-GRANT on source 2 together with a transfer -> next cycle gnt_o=0000, valid_o=0, sel_o=00; next grant with req_i=1111 goes to source 0.
REQ-034 SHALL cover: MAX_BURST=1, req_i=1010 -> grants alternate 1,3,1,3, each with exactly one transfer.
